// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD-to-binary converter.
package bcd_pkg;

    localparam int DIGIT_W           = 4;
    localparam int BCD_MAX           = 9;
    localparam int ADJ_THRESH        = 8;
    localparam int ADJ_VALUE         = 3;
    localparam int DEFAULT_DIGITS    = 8;
    localparam int DEFAULT_BIN_WIDTH = 27;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CORRECT = 2'd2,
        OVER    = 2'd3
    } state_e;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Single-digit reverse double-dabble correction: digits >= 8 lose 3, others pass.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    // Correct one digit after a right shift
    always_comb begin
        if (digit_i >= DIGIT_W'(ADJ_THRESH)) begin
            digit_o = digit_i - DIGIT_W'(ADJ_VALUE);
        end else begin
            digit_o = digit_i;
        end
    end

endmodule

// File: rtl/bcd_to_binary_chk.sv
// Invariant checks for the converter: BCD register drains fully, OVER lasts one cycle.
module bcd_to_binary_chk
    import bcd_pkg::*;
#(
    parameter int BCD_W = 32
) (
    input logic             clk,
    input logic             rst,
    input state_e           state_i,
    input logic             err_i,
    input logic [BCD_W-1:0] bcd_i
);

    property p_bcd_drained;
        @(posedge clk) disable iff (rst)
            (state_i == OVER && !err_i) |-> (bcd_i == '0);
    endproperty

    property p_over_single;
        @(posedge clk) disable iff (rst)
            (state_i == OVER) |=> (state_i == IDLE);
    endproperty

    a_bcd_drained: assert property (p_bcd_drained)
        else $error("bcd register not drained at end of conversion");
    a_over_single: assert property (p_over_single)
        else $error("OVER state lasted more than one cycle");

endmodule

// File: rtl/bcd_to_binary.sv
// Iterative packed-BCD to binary converter (reverse double-dabble) with
// start/ready/done handshake; DIGITS digits in, BIN_WIDTH-bit result out.
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int DIGITS    = DEFAULT_DIGITS,
    parameter int BIN_WIDTH = DEFAULT_BIN_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*DIGITS-1:0]    bcdValue,
    output logic                   ready,
    output logic                   done,
    output logic                   error,
    output logic [BIN_WIDTH-1:0]   binaryValue
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    state_e               state_q,  state_d;
    logic [BCD_W-1:0]     bcd_q,    bcd_d;
    logic [BIN_WIDTH-1:0] bin_q,    bin_d;
    logic [CNT_W-1:0]     count_q,  count_d;
    logic                 err_q,    err_d;
    logic [BIN_WIDTH-1:0] result_q, result_d;

    logic [BCD_W-1:0]     adj_s;
    logic [CNT_W-1:0]     count_inc_s;
    logic                 any_bad_s;
    logic                 last_shift_s;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adjust u_adj (
                .digit_i (bcd_q[g*DIGIT_W +: DIGIT_W]),
                .digit_o (adj_s[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    assign count_inc_s  = count_q + CNT_W'(1);
    assign last_shift_s = (count_inc_s == CNT_W'(BIN_WIDTH));

    // Flag any input digit outside 0..9
    always_comb begin
        any_bad_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcdValue[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX)) begin
                any_bad_s = 1'b1;
            end else begin
                any_bad_s = any_bad_s;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bcd_q    <= '0;
            bin_q    <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            bcd_q    <= bcd_d;
            bin_q    <= bin_d;
            count_q  <= count_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = any_bad_s ? OVER : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (last_shift_s) begin
                    state_d = OVER;
                end else begin
                    state_d = CORRECT;
                end
            end
            CORRECT: state_d = SHIFT;
            OVER:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; the last shift is never followed by a correction
    always_comb begin
        bcd_d    = bcd_q;
        bin_d    = bin_q;
        count_d  = count_q;
        err_d    = err_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bcd_d   = bcdValue;
                    bin_d   = '0;
                    count_d = '0;
                    err_d   = any_bad_s;
                    if (any_bad_s) begin
                        result_d = '0;
                    end else begin
                        result_d = result_q;
                    end
                end else begin
                    bcd_d = bcd_q;
                end
            end
            SHIFT: begin
                bcd_d   = bcd_q >> 1;
                bin_d   = {bcd_q[0], bin_q[BIN_WIDTH-1:1]};
                count_d = count_inc_s;
            end
            CORRECT: bcd_d = adj_s;
            OVER: begin
                if (!err_q) begin
                    result_d = bin_q;
                end else begin
                    result_d = result_q;
                end
            end
            default: bcd_d = bcd_q;
        endcase
    end

    // Moore outputs decoded from registered state
    always_comb begin
        ready       = (state_q == IDLE);
        done        = (state_q == OVER);
        error       = err_q;
        binaryValue = result_q;
    end

    bcd_to_binary_chk #(
        .BCD_W (BCD_W)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .state_i (state_q),
        .err_i   (err_q),
        .bcd_i   (bcd_q)
    );

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: expected results are queued at start and
// compared when done pulses.
module tb_bcd_to_binary;

    localparam int BW        = 27;
    localparam int VALID_LAT = 53;   // done seen after the 53rd edge past acceptance (54th cycle)
    localparam int PERIOD    = 55;   // start held high: IDLE + 53 busy + OVER

    typedef struct {
        logic [BW-1:0] bin;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   bcdValue;
    logic          ready;
    logic          done;
    logic          error;
    logic [BW-1:0] binaryValue;

    int   passed = 0;
    int   total  = 0;
    exp_t sb[$];

    bcd_to_binary dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bcdValue    (bcdValue),
        .ready       (ready),
        .done        (done),
        .error       (error),
        .binaryValue (binaryValue)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t ref_model(input logic [31:0] v);
        exp_t        e;
        longint      acc;
        logic [3:0]  d;
        e.err = 1'b0;
        acc   = 0;
        for (int i = 7; i >= 0; i--) begin
            d   = v[i*4 +: 4];
            if (d > 4'd9) e.err = 1'b1;
            acc = acc * 10 + longint'(d);
        end
        e.bin = e.err ? '0 : acc[BW-1:0];
        return e;
    endfunction

    function automatic logic [31:0] rand_bcd();
        logic [31:0] v;
        for (int i = 0; i < 8; i++) v[i*4 +: 4] = 4'($urandom_range(9, 0));
        return v;
    endfunction

    // One full conversion; optionally pokes start/bcdValue while busy at cycle poke_at
    task automatic convert(input logic [31:0] v, input int poke_at, input logic [31:0] poke_v);
        exp_t e;
        int   lat;
        int   exp_lat;
        logic busy_bad;
        sb.push_back(ref_model(v));
        exp_lat  = ref_model(v).err ? 0 : VALID_LAT;
        busy_bad = 1'b0;
        lat      = -1;
        bcdValue = v;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        bcdValue = $urandom;
        for (int k = 0; k < 200; k++) begin
            if (k == poke_at) begin
                start    = 1'b1;
                bcdValue = poke_v;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (ready !== 1'b0) busy_bad = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        total++;
        if (lat !== exp_lat) $display("FAIL latency v=%h: got %0d want %0d", v, lat, exp_lat);
        else passed++;
        total++;
        if (busy_bad !== 1'b0) $display("FAIL busy_ready v=%h: ready seen high while busy", v);
        else passed++;
        e = sb.pop_front();
        @(posedge clk); #1;
        total++;
        if (binaryValue !== e.bin) $display("FAIL result v=%h: got %h want %h", v, binaryValue, e.bin);
        else passed++;
        total++;
        if (error !== e.err) $display("FAIL error v=%h: got %b want %b", v, error, e.err);
        else passed++;
        total++;
        if (ready !== 1'b1 || done !== 1'b0)
            $display("FAIL post_done v=%h: ready=%b done=%b want ready=1 done=0", v, ready, done);
        else passed++;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        bcdValue = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (ready !== 1'b1 || done !== 1'b0 || error !== 1'b0 || binaryValue !== '0)
            $display("FAIL reset_state: ready=%b done=%b error=%b bin=%h want 1 0 0 0",
                     ready, done, error, binaryValue);
        else passed++;
    endtask

    task automatic test_zero();
        convert(32'h0000_0000, -1, 32'h0);
    endtask

    task automatic test_values();
        convert(32'h1234_5678, -1, 32'h0);
        convert(32'h9999_9999, -1, 32'h0);
    endtask

    task automatic test_invalid();
        convert(32'h0000_000A, -1, 32'h0);
        convert(32'hF000_0000, -1, 32'h0);
        convert(32'h0000_0042, -1, 32'h0);
    endtask

    task automatic test_busy_start();
        convert(32'h0000_1234, 10, 32'h0000_5678);
    endtask

    task automatic test_reset_mid();
        bcdValue = 32'h8765_4321;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        total++;
        if (ready !== 1'b1 || done !== 1'b0 || binaryValue !== '0 || error !== 1'b0)
            $display("FAIL mid_reset_async: ready=%b done=%b error=%b bin=%h want 1 0 0 0",
                     ready, done, error, binaryValue);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (ready !== 1'b1 || done !== 1'b0 || binaryValue !== '0)
            $display("FAIL mid_reset_release: ready=%b done=%b bin=%h want 1 0 0",
                     ready, done, binaryValue);
        else passed++;
        convert(32'h0000_0001, -1, 32'h0);
    endtask

    task automatic test_back_to_back();
        int   t;
        int   pulses;
        int   at[3];
        logic chk_next;
        exp_t e;
        for (int i = 0; i < 3; i++) sb.push_back(ref_model(32'h0000_0007));
        pulses   = 0;
        chk_next = 1'b0;
        t        = 0;
        bcdValue = 32'h0000_0007;
        start    = 1'b1;
        while (t < 400 && !(pulses == 3 && !chk_next)) begin
            @(posedge clk); #1;
            t++;
            if (chk_next) begin
                chk_next = 1'b0;
                e = sb.pop_front();
                total++;
                if (binaryValue !== e.bin) $display("FAIL b2b_result: got %h want %h", binaryValue, e.bin);
                else passed++;
            end
            if (done === 1'b1) begin
                if (pulses < 3) at[pulses] = t;
                pulses++;
                chk_next = 1'b1;
                if (pulses == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        total++;
        if (pulses !== 3) $display("FAIL b2b_pulses: got %0d want 3", pulses);
        else passed++;
        total++;
        if (at[0] !== VALID_LAT + 1) $display("FAIL b2b_first: got %0d want %0d", at[0], VALID_LAT + 1);
        else passed++;
        total++;
        if (at[1] - at[0] !== PERIOD || at[2] - at[1] !== PERIOD)
            $display("FAIL b2b_period: got %0d,%0d want %0d", at[1] - at[0], at[2] - at[1], PERIOD);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (ready !== 1'b1) $display("FAIL b2b_idle: ready=%b want 1", ready);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) convert(rand_bcd(), -1, 32'h0);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_values();
        test_invalid();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        total++;
        if (sb.size() !== 0) $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
